// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered status flags, occupancy count and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [FIFO_DEPTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int ENTRIES = 2**FIFO_DEPTH;
  localparam int PW      = FIFO_DEPTH + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(ENTRIES);
  localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] count_reg, count_next;
  logic          full_reg, empty_reg, afull_reg, aempty_reg;
  logic          ovf_reg, ovf_next, udf_reg, udf_next;
  logic          rd_accept, wr_accept;
  logic [DATA_WIDTH-1:0] dout_reg;

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  always_comb begin
    rd_accept   = rd_en && !empty_reg;
    wr_accept   = wr_en && (!full_reg || rd_accept);
    wr_ptr_next = wr_ptr_reg + {{FIFO_DEPTH{1'b0}}, wr_accept};
    rd_ptr_next = rd_ptr_reg + {{FIFO_DEPTH{1'b0}}, rd_accept};
    count_next  = wr_ptr_next - rd_ptr_next;
    ovf_next    = (ovf_reg && !err_clr) || (wr_en && !wr_accept);
    udf_next    = (udf_reg && !err_clr) || (rd_en && empty_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == FULL_CNT);
      empty_reg  <= (count_next == '0);
      afull_reg  <= (count_next >= AFULL_T);
      aempty_reg <= (count_next <= AEMPTY_T);
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
    end
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[FIFO_DEPTH-1:0]] <= din;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic wr_to_head;

  // The entry being written becomes the head when the FIFO drains to it on this edge.
  assign wr_to_head = wr_accept && (wr_ptr_reg == rd_ptr_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg <= '0;
    end else if (wr_to_head) begin
      dout_reg <= din;
    end else begin
      dout_reg <= mem[rd_ptr_next[FIFO_DEPTH-1:0]];
    end
  end

  assign dout_valid = !empty_reg;
`else
  logic dout_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= rd_accept;
      if (rd_accept) begin
        dout_reg <= mem[rd_ptr_reg[FIFO_DEPTH-1:0]];
      end
    end
  end

  assign dout_valid = dout_valid_reg;
`endif

  assign dout         = dout_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign count        = count_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags; checks every output after every clock edge.
// Build with SYNC_FIFO_FWFT_EN defined to exercise the first-word-fall-through read path.
module tb_sync_fifo_flags;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int AF_TH   = 12;
  localparam int AE_TH   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  int            tests_run    = 0;
  int            tests_failed = 0;

  logic [DW-1:0] sb [$];
  int            m_count;
  logic          m_ovf;
  logic          m_udf;
  logic          m_valid;
  logic [DW-1:0] m_dout;

  sync_fifo_flags dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("count", 32'(count), 32'(m_count));
    check_val("full", 32'(full), 32'(m_count == DEPTH));
    check_val("empty", 32'(empty), 32'(m_count == 0));
    check_val("almost_full", 32'(almost_full), 32'(m_count >= AF_TH));
    check_val("almost_empty", 32'(almost_empty), 32'(m_count <= AE_TH));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    m_valid = (m_count != 0);
    check_val("dout_valid", 32'(dout_valid), 32'(m_valid));
    if (m_valid) begin
      check_val("dout_head", 32'(dout), 32'(sb[0]));
    end
`else
    check_val("dout_valid", 32'(dout_valid), 32'(m_valid));
    check_val("dout", 32'(dout), 32'(m_dout));
`endif
  endtask

  // One clock of stimulus; the model advances from its pre-edge state, then outputs are compared.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
    logic rd_ok;
    logic wr_ok;
    wr_en   = w;
    din     = d;
    rd_en   = r;
    err_clr = clr;
    @(posedge clk);
    rd_ok   = r && (m_count != 0);
    wr_ok   = w && ((m_count != DEPTH) || rd_ok);
    m_ovf   = (m_ovf && !clr) || (w && !wr_ok);
    m_udf   = (m_udf && !clr) || (r && (m_count == 0));
    m_valid = rd_ok;
    if (rd_ok) m_dout = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    m_count = sb.size();
    #1;
    $display("[TB] t=%0t wr=%0b din=%02h rd=%0b clr=%0b -> count=%0d dout=%02h valid=%0b ovf=%0b udf=%0b",
             $time, w, d, r, clr, count, dout, dout_valid, overflow, underflow);
    check_outputs();
  endtask

  // Reset with other inputs active to confirm reset priority.
  task automatic do_reset(input logic w, input logic r);
    rst     = 1'b1;
    wr_en   = w;
    din     = 8'hFF;
    rd_en   = r;
    err_clr = 1'b0;
    @(posedge clk);
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_valid = 1'b0;
    m_dout  = '0;
    #1;
    $display("[TB] t=%0t reset -> count=%0d empty=%0b dout=%02h", $time, count, empty, dout);
    check_outputs();
    check_val("rst_dout", 32'(dout), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; din = '0; rd_en = 1'b0; err_clr = 1'b0;
    do_reset(1'b0, 1'b0);

    // Fill to full, then overflow.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'd17, 1'b0, 1'b0);

    // Drain in order, then underflow on empty.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous read/write at full and at half occupancy.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Write concurrent with a dropped read on empty.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Random interleaving across pointer wrap.
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 9) < 6), DW'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 5), ($urandom_range(0, 15) == 0));
      check_val("count_le_depth", 32'(count <= 5'd16), 32'h1);
    end

    // Reset mid-operation, then confirm no stale data.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
